chacha_block_finalizer: RTL and testbench

Downstream stage of PerformQround. On a blockready pulse it snapshots the 20-round output matrix and the original input matrix. It performs the ChaCha20 feed-forward addition (word-wise mod 2^32), one row per cycle. It then streams the 16 keystream words out over a valid/ready handshake to the Poly1305/XOR datapath.

---
 rtl/chacha_block_finalizer.sv | 152 +++++++++++++++
 tb/tb_chacha_block_finalizer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/chacha_block_finalizer.sv
// ChaCha20 block finalizer: snapshots the round output and the original state,
// adds them one row per cycle, then streams 16 keystream words over valid/ready.
module chacha_block_finalizer #(
  parameter int CNT_W  = 8,
  parameter int WORD_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0][3:0][WORD_W-1:0]   init_state,
  input  logic [3:0][3:0][WORD_W-1:0]   round_state,
  input  logic                          blockready,
  output logic [WORD_W-1:0]             ks_word,
  output logic                          ks_valid,
  input  logic                          ks_ready,
  output logic                          ks_last,
  output logic                          idle,
  output logic                          overrun,
  output logic [CNT_W-1:0]              blocks_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADD, ST_STREAM} state_t;

  state_t                        state_q, state_d;
  logic [1:0]                    row_q, row_d;
  logic [3:0]                    widx_q, widx_d;
  logic [WORD_W-1:0]             word_q, word_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic                          idle_q, idle_d;
  logic                          overrun_q, overrun_d;
  logic [CNT_W-1:0]              done_q, done_d;
  logic                          capture_s, add_s;
  logic [3:0]                    next_idx_s;
  logic [3:0][3:0][WORD_W-1:0]   snap_init_q, snap_round_q, buf_q;

  // Row-major word k of the finished matrix lives at [k>>2][k&3].
  function automatic logic [WORD_W-1:0] word_at(input logic [3:0][3:0][WORD_W-1:0] m,
                                                input logic [3:0] k);
    word_at = m[k[3:2]][k[1:0]];
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    widx_d     = widx_q;
    word_d     = word_q;
    valid_d    = valid_q;
    last_d     = last_q;
    overrun_d  = 1'b0;
    done_d     = done_q;
    capture_s  = 1'b0;
    add_s      = 1'b0;
    next_idx_s = widx_q + 4'd1;
    case (state_q)
      ST_IDLE: begin
        if (blockready) begin
          capture_s = 1'b1;
          row_d     = 2'd0;
          state_d   = ST_ADD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ADD: begin
        add_s     = 1'b1;
        overrun_d = blockready;
        row_d     = row_q + 2'd1;
        // Row 0 was summed three cycles ago, so word 0 can be preloaded now.
        if (row_q == 2'd3) begin
          state_d = ST_STREAM;
          widx_d  = 4'd0;
          word_d  = word_at(buf_q, 4'd0);
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_STREAM: begin
        overrun_d = blockready;
        if (valid_q && ks_ready) begin
          if (widx_q == 4'd15) begin
            state_d = ST_IDLE;
            widx_d  = 4'd0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = done_q + CNT_W'(1);
          end else begin
            widx_d  = next_idx_s;
            word_d  = word_at(buf_q, next_idx_s);
            last_d  = (next_idx_s == 4'd15);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= 2'd0;
      widx_q    <= 4'd0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      idle_q    <= 1'b1;
      overrun_q <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      widx_q    <= widx_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  // Snapshot and feed-forward buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      snap_init_q  <= init_state;
      snap_round_q <= round_state;
    end
    if (add_s) begin
      for (int j = 0; j < 4; j++) begin
        buf_q[row_q][j] <= snap_round_q[row_q][j] + snap_init_q[row_q][j];
      end
    end
  end

  assign ks_word     = word_q;
  assign ks_valid    = valid_q;
  assign ks_last     = last_q;
  assign idle        = idle_q;
  assign overrun     = overrun_q;
  assign blocks_done = done_q;

endmodule

// File: tb/tb_chacha_block_finalizer.sv
// Directed self-checking bench for chacha_block_finalizer (counter width 2 so
// wrap-around of blocks_done is reachable).
module tb_chacha_block_finalizer;

  logic                     clk;
  logic                     rst;
  logic [3:0][3:0][31:0]    init_s;
  logic [3:0][3:0][31:0]    round_s;
  logic                     blockready;
  logic [31:0]              ks_word;
  logic                     ks_valid;
  logic                     ks_ready;
  logic                     ks_last;
  logic                     idle;
  logic                     overrun;
  logic [1:0]               blocks_done;

  int          nvec;
  int          nerr;
  logic [1:0]  exp_done;
  logic [31:0] exp_w [16];

  chacha_block_finalizer #(.CNT_W(2), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .init_state  (init_s),
    .round_state (round_s),
    .blockready  (blockready),
    .ks_word     (ks_word),
    .ks_valid    (ks_valid),
    .ks_ready    (ks_ready),
    .ks_last     (ks_last),
    .idle        (idle),
    .overrun     (overrun),
    .blocks_done (blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse blockready for one edge (E0) and check ks_valid rises exactly after E0+4.
  task automatic start_block();
    @(negedge clk);
    chk("idle_before", {31'd0, idle}, 32'd1);
    blockready = 1'b1;
    @(negedge clk);
    blockready = 1'b0;
    chk("overrun_quiet", {31'd0, overrun}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("latency_low", {31'd0, ks_valid}, 32'd0);
    end
    @(negedge clk);
    chk("latency_high", {31'd0, ks_valid}, 32'd1);
    chk("idle_busy", {31'd0, idle}, 32'd0);
  endtask

  // Consume one block, comparing against exp_w; optionally random ready and a
  // second blockready injected when word ovr_at is presented.
  task automatic recv(input bit rnd, input int ovr_at);
    int k = 0;
    int cyc = 0;
    int ovr_state = 0;
    bit rdy;
    while (k < 16 && cyc < 400) begin
      if (ovr_state == 2) begin
        chk("overrun_gone", {31'd0, overrun}, 32'd0);
        ovr_state = 3;
      end
      if (ovr_state == 1) begin
        blockready = 1'b0;
        chk("overrun_pulse", {31'd0, overrun}, 32'd1);
        ovr_state = 2;
      end
      if (ovr_at == k && ovr_state == 0) begin
        blockready = 1'b1;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            round_s[i][j] = 32'hDEAD0000 + 32'(16 * i + j);
        ovr_state = 1;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("stream_valid", {31'd0, ks_valid}, 32'd1);
      chk($sformatf("word%0d", k), ks_word, exp_w[k]);
      chk($sformatf("last%0d", k), {31'd0, ks_last}, {31'd0, (k == 15)});
      ks_ready = rdy;
      if (ks_valid && rdy) k++;
      @(negedge clk);
      cyc++;
    end
    ks_ready   = 1'b0;
    blockready = 1'b0;
    chk("transfer_count", 32'(k), 32'd16);
    exp_done = exp_done + 2'd1;
    chk("valid_drop", {31'd0, ks_valid}, 32'd0);
    chk("idle_after", {31'd0, idle}, 32'd1);
    chk("blocks_done", {30'd0, blocks_done}, {30'd0, exp_done});
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    exp_done = 2'd0;
    rst = 1'b1;
    blockready = 1'b0;
    ks_ready = 1'b0;
    init_s = '0;
    round_s = '0;
    #3;
    chk("rst_valid", {31'd0, ks_valid}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_last", {31'd0, ks_last}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_word", ks_word, 32'd0);
    chk("rst_done", {30'd0, blocks_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Wrap add: 0xFFFFFFFF + 1 = 0 in every word
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        init_s[i][j]  = 32'h00000001;
        round_s[i][j] = 32'hFFFFFFFF;
      end
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h00000000;
    start_block();
    recv(1'b0, -1);

    // Ordering: word k = 0x100*(k>>2) + (k&3)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        init_s[i][j]  = 32'd0;
        round_s[i][j] = 32'(32'h100 * i + j);
      end
    for (int k = 0; k < 16; k++) exp_w[k] = 32'(32'h100 * (k / 4) + (k % 4));
    start_block();
    recv(1'b0, -1);

    // Backpressure with the same data
    start_block();
    recv(1'b1, -1);

    // Overrun at word 5 with different round data; counter wraps 3 -> 0 here
    start_block();
    recv(1'b0, 5);

    // Counter wrap: five back-to-back blocks, blocks_done 1,2,3,0,1
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          init_s[i][j]  = 32'(b);
          round_s[i][j] = 32'(32'h100 * i + j);
        end
      for (int k = 0; k < 16; k++) exp_w[k] = 32'(32'h100 * (k / 4) + (k % 4) + b);
      start_block();
      recv(1'b0, -1);
    end

    // Asynchronous reset mid-stream
    start_block();
    ks_ready = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_done = 2'd0;
    chk("midrst_valid", {31'd0, ks_valid}, 32'd0);
    chk("midrst_idle", {31'd0, idle}, 32'd1);
    chk("midrst_done", {30'd0, blocks_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, ks_valid}, 32'd0);
      chk("post_rst_idle", {31'd0, idle}, 32'd1);
    end
    ks_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
